// File: rtl/vga_axi_lite_pkg.sv
// Register map, FSM state types and helpers shared by the VGA
// control-register block.
package vga_axi_lite_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_BUBX     = 3'd1;
    localparam logic [2:0] ADDR_BUBY     = 3'd2;
    localparam logic [2:0] ADDR_COLOR    = 3'd3;
    localparam logic [2:0] ADDR_FRAMECNT = 3'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_axi_lite_regs.sv
// AXI4-Lite slave exposing the VGA bubble control registers and a
// free-running frame counter driven by vsync_pulse.
module vga_axi_lite_regs
    import vga_axi_lite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            vsync_pulse,
    output logic                            vga_enable,
    output logic [9:0]                      bubble_x,
    output logic [8:0]                      bubble_y,
    output logic [11:0]                     bubble_color
);

    wr_state_t   wr_state;
    rd_state_t   rd_state;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic [2:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic [3:0]  wr_strb_q;

    logic [31:0] ctrl_q;
    logic [31:0] bubx_q;
    logic [31:0] buby_q;
    logic [31:0] color_q;
    logic [31:0] framecnt_q;

    logic        aw_hs;
    logic        w_hs;
    logic        commit;
    logic [2:0]  commit_addr;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;
    logic        frame_clear;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;

    // The commit happens on the edge that moves the FSM into WR_RESP,
    // taking whichever half arrives this cycle straight off the bus.
    always_comb begin
        commit = 1'b0;
        case (wr_state)
            WR_IDLE: commit = aw_hs && w_hs;
            WR_ADDR: commit = w_hs;
            WR_DATA: commit = aw_hs;
            default: commit = 1'b0;
        endcase
        commit_addr = aw_hs ? S_AXI_AWADDR[4:2] : wr_addr_q;
        commit_data = w_hs ? S_AXI_WDATA : wr_data_q;
        commit_strb = w_hs ? S_AXI_WSTRB : wr_strb_q;
    end

    assign frame_clear = commit && (commit_addr == ADDR_CTRL)
                      && commit_strb[0] && commit_data[CTRL_CLEAR_BIT];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state  <= WR_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state  <= WR_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                    end else if (aw_hs) begin
                        wr_state  <= WR_ADDR;
                        awready_q <= 1'b0;
                        wr_addr_q <= S_AXI_AWADDR[4:2];
                    end else if (w_hs) begin
                        wr_state  <= WR_DATA;
                        wready_q  <= 1'b0;
                        wr_data_q <= S_AXI_WDATA;
                        wr_strb_q <= S_AXI_WSTRB;
                    end
                end
                WR_ADDR: begin
                    if (w_hs) begin
                        wr_state <= WR_RESP;
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (aw_hs) begin
                        wr_state  <= WR_RESP;
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                    end
                end
                default: begin
                    if (S_AXI_BREADY) begin
                        wr_state  <= WR_IDLE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        bvalid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_q     <= '0;
            bubx_q     <= '0;
            buby_q     <= '0;
            color_q    <= '0;
            framecnt_q <= '0;
        end else begin
            if (commit) begin
                case (commit_addr)
                    ADDR_CTRL: begin
                        ctrl_q <= apply_wstrb(ctrl_q, commit_data, commit_strb)
                                & ~(32'd1 << CTRL_CLEAR_BIT);
                    end
                    ADDR_BUBX:
                        bubx_q <= apply_wstrb(bubx_q, commit_data, commit_strb);
                    ADDR_BUBY:
                        buby_q <= apply_wstrb(buby_q, commit_data, commit_strb);
                    ADDR_COLOR:
                        color_q <= apply_wstrb(color_q, commit_data, commit_strb);
                    default: ;
                endcase
            end
            if (frame_clear) begin
                framecnt_q <= '0;
            end else if (vsync_pulse) begin
                framecnt_q <= framecnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[4:2])
            ADDR_CTRL:     rd_word = ctrl_q;
            ADDR_BUBX:     rd_word = bubx_q;
            ADDR_BUBY:     rd_word = buby_q;
            ADDR_COLOR:    rd_word = color_q;
            ADDR_FRAMECNT: rd_word = framecnt_q;
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        rd_state  <= RD_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_word;
                    end
                end
                default: begin
                    if (S_AXI_RREADY) begin
                        rd_state  <= RD_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign vga_enable   = ctrl_q[CTRL_ENABLE_BIT];
    assign bubble_x     = bubx_q[9:0];
    assign bubble_y     = buby_q[8:0];
    assign bubble_color = color_q[11:0];

endmodule

// File: doc/vga_axi_lite_regs.md
VGA_AXI_LITE_REGS -- requirements
Module: vga_axi_lite_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have these AXI4-Lite slave ports:
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
REQ-005 SHALL have these VGA-side ports:
- vsync_pulse  in  1  one-cycle frame-start strobe.
- vga_enable  out  1  CTRL[0].
- bubble_x  out  10  BUBX[9:0].
- bubble_y  out  9  BUBY[8:0].
- bubble_color  out  12  COLOR[11:0].

Function
REQ-006 SHALL decode register words by address bits [4:2]; bits [1:0] are ignored. The map SHALL be:
- 0x00 CTRL, RW.
- 0x04 BUBX, RW.
- 0x08 BUBY, RW.
- 0x0C COLOR, RW.
- 0x10 FRAMECNT, RO.
- 0x14–0x1C unmapped.
REQ-007 RW registers SHALL store all 32 bits and read back exactly as written, with one exception: CTRL[1] is a self-clearing strobe that is never stored and always reads 0.
REQ-008 The write FSM SHALL have four states with these ready outputs:
- WR_IDLE: AWREADY=1, WREADY=1.
- WR_ADDR (address held, awaiting data): AWREADY=0, WREADY=1.
- WR_DATA (data held, awaiting address): AWREADY=1, WREADY=0.
- WR_RESP: AWREADY=0, WREADY=0.
REQ-009 From WR_IDLE, the write FSM SHALL move to WR_RESP if both AW and W handshake in the same cycle, to WR_ADDR if only AW handshakes, and to WR_DATA if only W handshakes.
REQ-010 From WR_ADDR on a W handshake, and from WR_DATA on an AW handshake, the write FSM SHALL move to WR_RESP.
REQ-011 The register update SHALL occur on the cycle the write FSM enters WR_RESP, using WSTRB byte lanes; BVALID SHALL be 1 throughout WR_RESP.
REQ-012 From WR_RESP, the write FSM SHALL return to WR_IDLE on the cycle BVALID&&BREADY is true.
REQ-013 BRESP and RRESP SHALL always be 2'b00 (OKAY).
REQ-014 Writes to FRAMECNT or to unmapped addresses SHALL complete normally and change no state.
REQ-015 The read FSM SHALL have two states:
- RD_IDLE: ARREADY=1.
- RD_DATA: ARREADY=0, RVALID=1.
REQ-016 On an AR handshake the read FSM SHALL capture RDATA from the register state of that cycle and assert RVALID on the next cycle; unmapped addresses return 0.
REQ-017 RDATA SHALL be held stable in RD_DATA until RVALID&&RREADY, then the read FSM SHALL return to RD_IDLE.
REQ-018 The read and write channels SHALL operate independently. A read whose AR handshakes in the same cycle as a write update to the same address returns the pre-write value.
REQ-019 FRAMECNT SHALL increment by 1 per vsync_pulse and wrap from 0xFFFFFFFF to 0.
REQ-020 A write of CTRL[1]=1 (byte 0 strobed) SHALL clear FRAMECNT to 0; a coincident vsync_pulse is ignored, so clear wins.
REQ-021 The VGA outputs SHALL be driven directly from the register flops, with no added latency beyond the update cycle.

Reset
REQ-022 While ARESET=1, all registers, FRAMECNT, RDATA and the VGA outputs SHALL be 0.
REQ-023 While ARESET=1, BVALID and RVALID SHALL be 0 and both FSMs SHALL be in their IDLE states.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction with no register update and no response issued.

Structure
REQ-025 Package vga_axi_lite_pkg SHALL hold the register word-offset constants, the write/read state enums, the RESP_OKAY constant and the CTRL bit indices.
REQ-026 The block SHALL be a single module with no sub-module; the counter is too small to justify one.

Verification
REQ-027 Write 1,2,3,4 to 0x00,0x04,0x08,0x0C, then read them back -> 1,2,3,4 with RRESP=0; vga_enable=1, bubble_x=2, bubble_y=3, bubble_color=4.
REQ-028 W presented 3 cycles before AW -> WREADY then AWREADY each handshake once, one register update, and BVALID rises the cycle after the AW handshake.
REQ-029 Write 0xAABBCCDD to 0x04, then write 0x11223344 to 0x04 with WSTRB=4'b0101 -> readback 0xAA22CC44.
REQ-030 Hold BREADY=0 for 5 cycles -> BVALID held high and AWREADY/WREADY held low; likewise hold RREADY=0 -> RDATA stable for 5 cycles.
REQ-031 Give 3 vsync pulses -> FRAMECNT reads 3; write CTRL=0x3 coincident with a pulse -> FRAMECNT reads 0 and CTRL reads 0x1.
REQ-032 Assert ARESET during WR_ADDR, then read 0x04 -> 0, and the next write completes normally.
